// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port, variable-latency memory bus between
// the instruction-fetch port and the load/store port. Data has fixed priority
// over fetch; a watchdog aborts stuck accesses and raises a sticky bus_err.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall,
    output logic              bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, DATA, FETCH, DONE} state_t;

    state_t            state_q, state_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_valid_q, if_valid_d;
    logic              dm_valid_q, dm_valid_d;
    logic              bus_err_q, bus_err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Next-state and registered-output computation for the arbitration FSM
    always_comb begin
        state_d     = state_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        bus_err_d   = bus_err_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (dm_req) begin
                    state_d     = DATA;
                    mem_en_d    = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    cnt_d       = '0;
                end else if (if_req) begin
                    state_d    = FETCH;
                    mem_en_d   = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                    cnt_d      = '0;
                end
            end
            DATA, FETCH: begin
                if (mem_ready) begin
                    state_d  = DONE;
                    mem_en_d = 1'b0;
                    if (state_q == DATA) begin
                        if (!mem_we_q) dm_rdata_d = mem_rdata;
                        dm_valid_d = 1'b1;
                    end else begin
                        if_rdata_d = mem_rdata;
                        if_valid_d = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = DONE;
                    mem_en_d  = 1'b0;
                    bus_err_d = 1'b1;
                    if (state_q == DATA) begin
                        dm_rdata_d = '0;
                        dm_valid_d = 1'b1;
                    end else begin
                        if_rdata_d = '0;
                        if_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_valid_q  <= if_valid_d;
            dm_valid_q  <= dm_valid_d;
            bus_err_q   <= bus_err_d;
            cnt_q       <= cnt_d;
        end
    end

    // Output drive; stall holds the pipeline until the owner's completion pulse
    always_comb begin
        mem_en    = mem_en_q;
        mem_we    = mem_we_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        if_rdata  = if_rdata_q;
        dm_rdata  = dm_rdata_q;
        if_valid  = if_valid_q;
        dm_valid  = dm_valid_q;
        bus_err   = bus_err_q;
        stall     = (dm_req & ~dm_valid_q) | (if_req & ~if_valid_q);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a bus responder model plus a result scoreboard,
// driven from a table of single transactions and hand-written corner sequences.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, dm_req, dm_we;
    logic [AW-1:0] if_addr, dm_addr, mem_addr;
    logic [DW-1:0] if_rdata, dm_rdata, dm_wdata, mem_wdata, mem_rdata;
    logic          if_valid, dm_valid, mem_en, mem_we, mem_ready, stall, bus_err;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall(stall), .bus_err(bus_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] data;
        int          len;
    } bus_t;

    typedef struct {
        logic        is_data;
        logic [31:0] rdata;
        logic        err;
        int          vcyc;
    } res_t;

    typedef struct {
        logic        is_data;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] bus_data;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    bus_t bus_q[$];
    res_t res_q[$];
    bus_t cur;
    int   en_cnt = 0;

    // Bus responder: ready on the delay-th mem_en cycle, junk ready/data while idle
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
    end

    always @(negedge clk) begin
        if (mem_en) begin
            if (en_cnt == 0) begin
                if (bus_q.size() == 0) begin
                    check("bus_unexpected", 32'd1, 32'd0);
                    cur = '{32'h0, 1'b0, 32'h0, 1, 32'h0, 1};
                end else begin
                    cur = bus_q.pop_front();
                end
            end
            en_cnt++;
            check("bus_addr", mem_addr, cur.addr);
            check("bus_we", {31'd0, mem_we}, {31'd0, cur.we});
            if (cur.we) check("bus_wdata", mem_wdata, cur.wdata);
            if (en_cnt > TO) check("bus_overrun", en_cnt, TO);
            mem_ready = (en_cnt == cur.delay);
            mem_rdata = mem_ready ? cur.data : 32'hBAD0_BAD0;
        end else begin
            if (en_cnt != 0) check("bus_len", en_cnt, cur.len);
            en_cnt    = 0;
            mem_ready = 1'b1;
            mem_rdata = 32'hDEAD_BEEF;
        end
    end

    task automatic issue(input vec_t v, input int exp_cyc);
        int len;
        len = (v.delay > TO) ? TO : v.delay;
        bus_q.push_back('{v.addr, v.we, v.wdata, v.delay, v.bus_data, len});
        res_q.push_back('{v.is_data, v.exp_rdata, v.exp_err, exp_cyc});
        if (v.is_data) begin
            dm_req   = 1'b1;
            dm_we    = v.we;
            dm_addr  = v.addr;
            dm_wdata = v.wdata;
        end else begin
            if_req  = 1'b1;
            if_addr = v.addr;
        end
    endtask

    task automatic wait_done(input int n);
        int   done;
        res_t r;
        done = 0;
        for (int i = 0; i < 64 && done < n; i++) begin
            @(negedge clk);
            check("valid_exclusive", {31'd0, if_valid & dm_valid}, 32'd0);
            if (dm_valid || if_valid) begin
                if (res_q.size() == 0) begin
                    check("valid_unexpected", 32'd1, 32'd0);
                end else begin
                    r = res_q.pop_front();
                    check("owner", {31'd0, dm_valid}, {31'd0, r.is_data});
                    check("rdata", r.is_data ? dm_rdata : if_rdata, r.rdata);
                    check("bus_err", {31'd0, bus_err}, {31'd0, r.err});
                    check("valid_cycle", cyc, r.vcyc);
                    check("stall_at_valid", {31'd0, stall},
                          {31'd0, r.is_data ? if_req : dm_req});
                end
                if (dm_valid) dm_req = 1'b0;
                else if_req = 1'b0;
                done++;
            end else begin
                check("stall_wait", {31'd0, stall}, {31'd0, dm_req | if_req});
            end
        end
        if (done < n) check("valid_timeout", done, n);
        @(negedge clk);
        check("valid_pulse", {30'd0, if_valid, dm_valid}, 32'd0);
        check("stall_idle", {31'd0, stall}, 32'd0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_mem_en"}, {31'd0, mem_en}, 32'd0);
        check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_if_rdata"}, if_rdata, 32'd0);
        check({tag, "_dm_rdata"}, dm_rdata, 32'd0);
        check({tag, "_valids"}, {30'd0, if_valid, dm_valid}, 32'd0);
        check({tag, "_bus_err"}, {31'd0, bus_err}, 32'd0);
        check({tag, "_stall"}, {31'd0, stall}, 32'd0);
    endtask

    vec_t vecs[7];
    vec_t v;
    int   c;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h40,  32'h0,         1,  32'h2401_0005, 32'h2401_0005, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 32'h300, 32'h0,         2,  32'h1234_5678, 32'h1234_5678, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'h200, 32'hCAFE_F00D, 3,  32'h0BAD_0BAD, 32'h1234_5678, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 32'h48,  32'h0,         4,  32'h5,         32'h5,         1'b0};
        vecs[4] = '{1'b0, 1'b0, 32'h4C,  32'h0,         99, 32'h1111,      32'h0,         1'b1};
        vecs[5] = '{1'b1, 1'b0, 32'h304, 32'h0,         1,  32'h77,        32'h77,        1'b1};
        vecs[6] = '{1'b1, 1'b1, 32'h208, 32'h55AA,      2,  32'h0BAD_0BAD, 32'h77,        1'b1};

        rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;
        repeat (2) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        // Single transactions, including the final-cycle ready and the timeout
        foreach (vecs[i]) begin
            issue(vecs[i], cyc + ((vecs[i].delay > TO) ? TO : vecs[i].delay) + 1);
            wait_done(1);
        end

        // Simultaneous load and fetch: load first, one turnaround, then fetch
        c = cyc;
        v = '{1'b1, 1'b0, 32'h100, 32'h0, 3, 32'h11, 32'h11, 1'b1};
        issue(v, c + 4);
        v = '{1'b0, 1'b0, 32'h44, 32'h0, 3, 32'h22, 32'h22, 1'b1};
        issue(v, c + 9);
        wait_done(2);

        // Reset during a load's second bus cycle
        bus_q.push_back('{32'h180, 1'b0, 32'h0, 99, 32'h0, 2});
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h180;
        @(negedge clk);
        check("midrst_en1", {31'd0, mem_en}, 32'd1);
        @(negedge clk);
        check("midrst_en2", {31'd0, mem_en}, 32'd1);
        rst = 1'b1; dm_req = 1'b0;
        @(negedge clk);
        check_reset("midrst");
        rst = 1'b0;
        @(negedge clk);
        check("midrst_no_valid", {30'd0, if_valid, dm_valid}, 32'd0);
        check("midrst_idle", {31'd0, mem_en}, 32'd0);

        // Re-issued load completes normally with a clean error flag
        v = '{1'b1, 1'b0, 32'h184, 32'h0, 2, 32'h99, 32'h99, 1'b0};
        issue(v, cyc + 3);
        wait_done(1);

        check("queues_empty", bus_q.size() + res_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
